// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - scancode-in / key-state-out bundle for the PS/2 key decoder
interface ps2_key_decoder_if;
    logic [7:0] code_byte;
    logic       code_valid;
    logic [7:0] key_held;
    logic [7:0] key_press;

    modport master (
        output code_byte,
        output code_valid,
        input  key_held,
        input  key_press
    );

    modport slave (
        input  code_byte,
        input  code_valid,
        output key_held,
        output key_press
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 prefix tracker, game-key map and DAS/ARR auto-repeat
module ps2_key_decoder #(
    parameter int DAS_DELAY   = 16_000_000,
    parameter int ARR_PERIOD  = 5_000_000,
    parameter int PFX_TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_decoder_if.slave bus
);

    localparam int RPT_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam int TMO_W   = $clog2(PFX_TIMEOUT);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       held_q;
    logic [7:0]       press_q;
    logic [RPT_W-1:0] rpt_cnt [3];
    logic [2:0]       rpt_arr;

    logic [7:0]       make_mask;
    logic [7:0]       brk_mask;
    logic [7:0]       held_next;
    logic [7:0]       press_next;
    logic [2:0]       rpt_fire;
    logic [RPT_W-1:0] rpt_lim [3];

    // One-hot key bit for a code; zero for anything unmapped, including prefixes.
    function automatic logic [7:0] key_map(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'h00;
        if (ext) begin
            case (code)
                8'h6B:   m = 8'h01;
                8'h74:   m = 8'h02;
                8'h72:   m = 8'h04;
                8'h75:   m = 8'h08;
                default: m = 8'h00;
            endcase
        end else begin
            case (code)
                8'h22:   m = 8'h08;
                8'h1A:   m = 8'h10;
                8'h29:   m = 8'h20;
                8'h21:   m = 8'h40;
                8'h76:   m = 8'h80;
                default: m = 8'h00;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        make_mask = 8'h00;
        brk_mask  = 8'h00;
        if (bus.code_valid) begin
            case (state)
                IDLE:    make_mask = key_map(bus.code_byte, 1'b0);
                EXT:     make_mask = key_map(bus.code_byte, 1'b1);
                BRK:     brk_mask  = key_map(bus.code_byte, 1'b0);
                EXT_BRK: brk_mask  = key_map(bus.code_byte, 1'b1);
                default: make_mask = 8'h00;
            endcase
        end
    end

    // A break clears the held bit before any repeat is considered, so it always wins.
    always_comb begin
        held_next  = (held_q | make_mask) & ~brk_mask;
        press_next = make_mask & ~held_q;
        rpt_fire   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            rpt_lim[k]  = rpt_arr[k] ? RPT_W'(ARR_PERIOD - 1) : RPT_W'(DAS_DELAY - 1);
            rpt_fire[k] = held_q[k] && !brk_mask[k] && (rpt_cnt[k] == rpt_lim[k]);
            if (rpt_fire[k])
                press_next[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            if (bus.code_valid) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.code_byte == 8'hE0)
                            state <= EXT;
                        else if (bus.code_byte == 8'hF0)
                            state <= BRK;
                    end
                    EXT: begin
                        if (bus.code_byte == 8'hF0)
                            state <= EXT_BRK;
                        else if (bus.code_byte != 8'hE0)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_W'(PFX_TIMEOUT - 1)) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= 8'h00;
            press_q <= 8'h00;
            rpt_arr <= 3'b000;
            for (int k = 0; k < 3; k++)
                rpt_cnt[k] <= '0;
        end else begin
            held_q  <= held_next;
            press_q <= press_next;
            // Counters idle at zero until the key is held, then run from the press pulse.
            for (int k = 0; k < 3; k++) begin
                if (!held_q[k] || brk_mask[k]) begin
                    rpt_cnt[k] <= '0;
                    rpt_arr[k] <= 1'b0;
                end else if (rpt_fire[k]) begin
                    rpt_cnt[k] <= '0;
                    rpt_arr[k] <= 1'b1;
                end else begin
                    rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign bus.key_held  = held_q;
    assign bus.key_press = press_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed bench with a cycle-level key model for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int DAS = 10;
    localparam int ARR = 4;
    localparam int PFX = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pcount [8];

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .DAS_DELAY  (DAS),
        .ARR_PERIOD (ARR),
        .PFX_TIMEOUT(PFX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int key_of(input logic [7:0] b, input bit ext);
        if (ext) begin
            if (b == 8'h6B) return 0;
            if (b == 8'h74) return 1;
            if (b == 8'h72) return 2;
            if (b == 8'h75) return 3;
        end else begin
            if (b == 8'h22) return 3;
            if (b == 8'h1A) return 4;
            if (b == 8'h29) return 5;
            if (b == 8'h21) return 6;
            if (b == 8'h76) return 7;
        end
        return -1;
    endfunction

    // Model: held keys, pending prefixes, and the cycle of each key's initial pulse.
    bit       m_held [8];
    bit       m_ext, m_brk;
    int       m_last;
    int       m_start [8];
    bit [7:0] m_press;

    always @(negedge clk) begin
        bit [7:0] nxt;
        bit [7:0] hv;
        int k, d;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_held[i]  = 0;
                m_start[i] = 0;
            end
            m_ext   = 0;
            m_brk   = 0;
            m_last  = 0;
            m_press = 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) hv[i] = m_held[i];
            check("key_held", bus.key_held, hv);
            check("key_press", bus.key_press, m_press);
            for (int i = 0; i < 8; i++)
                if (bus.key_press[i] === 1'b1) pcount[i]++;
            nxt = 8'h00;
            if (bus.code_valid) begin
                logic [7:0] b;
                b = bus.code_byte;
                if ((m_ext || m_brk) && (cyc - m_last > PFX)) begin
                    m_ext = 0;
                    m_brk = 0;
                end
                m_last = cyc;
                if (m_brk) begin
                    k = key_of(b, m_ext);
                    if (k >= 0) m_held[k] = 0;
                    m_ext = 0;
                    m_brk = 0;
                end else if (b == 8'hE0) begin
                    m_ext = 1;
                end else if (b == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    k = key_of(b, m_ext);
                    m_ext = 0;
                    if (k >= 0 && !m_held[k]) begin
                        m_held[k]  = 1;
                        m_start[k] = cyc + 1;
                        nxt[k]     = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (m_held[i] && !nxt[i]) begin
                    d = cyc + 1 - m_start[i];
                    if (d >= DAS && ((d - DAS) % ARR) == 0) nxt[i] = 1'b1;
                end
            end
            m_press = nxt;
        end
    end

    task automatic strobe(input logic [7:0] b);
        bus.code_byte  = b;
        bus.code_valid = 1'b1;
        @(posedge clk); #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 8; i++) pcount[i] = 0;
    endtask

    initial begin
        bus.code_byte  = 8'h00;
        bus.code_valid = 1'b0;
        clr_counts();
        @(posedge clk); #1;
        check("reset_held", bus.key_held, 8'h00);
        check("reset_press", bus.key_press, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Reset mid-frame with a key held and a pending E0.
        strobe(8'h1A);
        strobe(8'hE0);
        check("pre_rst_held", bus.key_held, 8'h10);
        rst = 1'b1;
        #2;
        check("async_rst_held", bus.key_held, 8'h00);
        check("async_rst_press", bus.key_press, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        clr_counts();
        strobe(8'h6B);
        idle(3);
        check("post_rst_6b_held", bus.key_held, 8'h00);
        check_int("post_rst_6b_pulses", pcount[0], 0);

        // Non-repeating key make and break.
        clr_counts();
        strobe(8'h1A);
        @(negedge clk);
        check("ccw_press", bus.key_press, 8'h10);
        check("ccw_held", bus.key_held, 8'h10);
        @(posedge clk); #1;
        check("ccw_press_gone", bus.key_press, 8'h00);
        idle(15);
        strobe(8'hF0);
        strobe(8'h1A);
        idle(3);
        check("ccw_released", bus.key_held, 8'h00);
        check_int("ccw_pulses", pcount[4], 1);

        // Left auto-repeat: P, P+10, P+14, P+18; break lands on P+22.
        clr_counts();
        strobe(8'hE0);
        strobe(8'h6B);
        idle(19);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        idle(20);
        check_int("left_repeat_pulses", pcount[0], 4);
        check("left_released", bus.key_held, 8'h00);

        // Typematic makes and an ignored ACK byte.
        clr_counts();
        strobe(8'h29);
        idle(3);
        strobe(8'h29);
        idle(3);
        strobe(8'h29);
        strobe(8'hFA);
        idle(3);
        check_int("hard_drop_pulses", pcount[5], 1);
        check("hard_drop_held", bus.key_held, 8'h20);
        strobe(8'hF0);
        strobe(8'h29);
        idle(2);

        // Prefix timeout: 20 idle cycles drops E0, 19 does not.
        clr_counts();
        strobe(8'hE0);
        idle(PFX);
        strobe(8'h74);
        idle(3);
        check("timeout_held", bus.key_held, 8'h00);
        check_int("timeout_pulses", pcount[1], 0);
        strobe(8'hE0);
        idle(PFX - 1);
        strobe(8'h74);
        @(negedge clk);
        check("no_timeout_press", bus.key_press, 8'h02);
        @(posedge clk); #1;
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h74);
        idle(2);

        // Rotate cw reached by two codes shares one held bit.
        clr_counts();
        strobe(8'h22);
        strobe(8'hE0);
        strobe(8'h75);
        idle(2);
        check_int("cw_pulses", pcount[3], 1);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h75);
        idle(2);
        check("cw_released", bus.key_held, 8'h00);

        // Left and right together; left break hits left's P0+18 repeat.
        clr_counts();
        strobe(8'hE0);
        strobe(8'h6B);
        strobe(8'hE0);
        strobe(8'h74);
        idle(13);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        idle(9);
        check_int("dual_left_pulses", pcount[0], 3);
        check_int("dual_right_pulses", pcount[1], 5);
        check("dual_right_held", bus.key_held, 8'h02);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h74);
        idle(5);
        check("all_released", bus.key_held, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
